// File: rtl/mdu_hilo.sv
// Iterative multiply/divide unit owning the HI/LO pair: radix-2 shift-add multiply,
// restoring divide, single-cycle MTHI/MTLO, abortable from any state.
module mdu_hilo #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             w_start,
  input  logic             w_abort,
  input  logic [5:0]       w_op_code_6,
  input  logic [WIDTH-1:0] w_input1_x,
  input  logic [WIDTH-1:0] w_input2_x,
  output logic             w_busy,
  output logic             w_done,
  output logic             w_div_zero,
  output logic [WIDTH-1:0] w_hi_x,
  output logic [WIDTH-1:0] w_lo_x
);

  localparam logic [5:0] SPECIAL_MTHI  = 6'h11;
  localparam logic [5:0] SPECIAL_MTLO  = 6'h13;
  localparam logic [5:0] SPECIAL_MULT  = 6'h18;
  localparam logic [5:0] SPECIAL_MULTU = 6'h19;
  localparam logic [5:0] SPECIAL_DIV   = 6'h1A;
  localparam logic [5:0] SPECIAL_DIVU  = 6'h1B;

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  logic [1:0]         r_state;
  logic [CW-1:0]      r_count;
  logic               r_is_div;
  logic               r_neg_q;
  logic               r_neg_r;
  logic               r_dz;
  logic [WIDTH-1:0]   r_op2;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_done;
  logic               r_div_zero;

  logic               w_is_muldiv;
  logic               w_is_div;
  logic               w_is_signed;
  logic               w_sign1;
  logic               w_sign2;
  logic [WIDTH-1:0]   w_mag1;
  logic [WIDTH-1:0]   w_mag2;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_trial;
  logic [WIDTH:0]     w_diff;
  logic [2*WIDTH-1:0] w_acc_next;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quot;
  logic [WIDTH-1:0]   w_rem;
  logic [WIDTH-1:0]   w_fix_hi;
  logic [WIDTH-1:0]   w_fix_lo;

  always_comb begin
    w_is_muldiv = (w_op_code_6 == SPECIAL_MULT) || (w_op_code_6 == SPECIAL_MULTU) ||
                  (w_op_code_6 == SPECIAL_DIV)  || (w_op_code_6 == SPECIAL_DIVU);
    w_is_div    = (w_op_code_6 == SPECIAL_DIV)  || (w_op_code_6 == SPECIAL_DIVU);
    w_is_signed = (w_op_code_6 == SPECIAL_MULT) || (w_op_code_6 == SPECIAL_DIV);
    w_sign1     = w_is_signed & w_input1_x[WIDTH-1];
    w_sign2     = w_is_signed & w_input2_x[WIDTH-1];
    w_mag1      = w_sign1 ? -w_input1_x : w_input1_x;
    w_mag2      = w_sign2 ? -w_input2_x : w_input2_x;
  end

  // One iteration: multiply adds r_op2 into the upper half and shifts right;
  // divide shifts the next dividend bit into the partial remainder and trial-subtracts.
  always_comb begin
    w_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_op2};
    w_trial = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    w_diff  = w_trial - {1'b0, r_op2};
    if (r_is_div) begin
      if (!w_diff[WIDTH]) w_acc_next = {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
      else                w_acc_next = {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
    end else begin
      if (r_acc[0]) w_acc_next = {w_sum, r_acc[WIDTH-1:1]};
      else          w_acc_next = {1'b0, r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1:1]};
    end
  end

  // With a zero divisor every trial succeeds, so the remainder ends as |dividend|
  // and its sign correction restores the latched dividend; only LO needs forcing.
  always_comb begin
    w_prod   = r_neg_q ? -r_acc : r_acc;
    w_quot   = r_dz ? '1 : (r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0]);
    w_rem    = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
    w_fix_hi = r_is_div ? w_rem  : w_prod[2*WIDTH-1:WIDTH];
    w_fix_lo = r_is_div ? w_quot : w_prod[WIDTH-1:0];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_count    <= '0;
      r_is_div   <= 1'b0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_dz       <= 1'b0;
      r_op2      <= '0;
      r_acc      <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_abort) begin
        r_state <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_start && w_is_muldiv) begin
              r_state    <= S_CALC;
              r_count    <= '0;
              r_is_div   <= w_is_div;
              r_neg_q    <= w_sign1 ^ w_sign2;
              r_neg_r    <= w_sign1;
              r_dz       <= w_is_div && (w_input2_x == '0);
              r_op2      <= w_is_div ? w_mag2 : w_mag1;
              r_acc      <= {{WIDTH{1'b0}}, (w_is_div ? w_mag1 : w_mag2)};
              r_div_zero <= 1'b0;
            end else if (w_start && (w_op_code_6 == SPECIAL_MTHI)) begin
              r_hi       <= w_input1_x;
              r_done     <= 1'b1;
              r_div_zero <= 1'b0;
            end else if (w_start && (w_op_code_6 == SPECIAL_MTLO)) begin
              r_lo       <= w_input1_x;
              r_done     <= 1'b1;
              r_div_zero <= 1'b0;
            end
          end
          S_CALC: begin
            r_acc   <= w_acc_next;
            r_count <= r_count + CW'(1);
            if (r_count == CW'(WIDTH - 1)) r_state <= S_FIX;
          end
          S_FIX: begin
            r_hi       <= w_fix_hi;
            r_lo       <= w_fix_lo;
            r_div_zero <= r_dz;
            r_done     <= 1'b1;
            r_state    <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign w_busy     = (r_state != S_IDLE);
  assign w_done     = r_done;
  assign w_div_zero = r_div_zero;
  assign w_hi_x     = r_hi;
  assign w_lo_x     = r_lo;

endmodule

// File: tb/tb_mdu_hilo.sv
// Bench for mdu_hilo: transaction-level reference model checked every cycle on a
// 32-bit instance, plus directed and random checks on an 8-bit instance.
module tb_mdu_hilo;

  localparam logic [5:0] OP_MTHI  = 6'h11;
  localparam logic [5:0] OP_MTLO  = 6'h13;
  localparam logic [5:0] OP_MULT  = 6'h18;
  localparam logic [5:0] OP_MULTU = 6'h19;
  localparam logic [5:0] OP_DIV   = 6'h1A;
  localparam logic [5:0] OP_DIVU  = 6'h1B;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, abort;
  logic [5:0]  op;
  logic [31:0] in1, in2;
  logic        busy, done, dz;
  logic [31:0] hi, lo;

  logic        start8, abort8;
  logic [5:0]  op8;
  logic [7:0]  a8, b8;
  logic        busy8, done8, dz8;
  logic [7:0]  hi8, lo8;

  mdu_hilo #(.WIDTH(32)) u_dut32 (
    .clock(clk), .reset(rst), .w_start(start), .w_abort(abort), .w_op_code_6(op),
    .w_input1_x(in1), .w_input2_x(in2), .w_busy(busy), .w_done(done),
    .w_div_zero(dz), .w_hi_x(hi), .w_lo_x(lo));

  mdu_hilo #(.WIDTH(8)) u_dut8 (
    .clock(clk), .reset(rst), .w_start(start8), .w_abort(abort8), .w_op_code_6(op8),
    .w_input1_x(a8), .w_input2_x(b8), .w_busy(busy8), .w_done(done8),
    .w_div_zero(dz8), .w_hi_x(hi8), .w_lo_x(lo8));

  int total = 0;
  int bad   = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Architectural result of one mul/div on w-bit operands, using plain integer arithmetic.
  function automatic void ref_op(input int w, input logic [5:0] o, input logic [31:0] a,
                                 input logic [31:0] b, output logic [31:0] rhi,
                                 output logic [31:0] rlo, output logic rdz);
    longint mask, half, ua, ub, sa, sb, h, l;
    logic [63:0] p;
    mask = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    ua = longint'(a) & mask;
    ub = longint'(b) & mask;
    sa = (ua ^ half) - half;
    sb = (ub ^ half) - half;
    rdz = 1'b0;
    h = 0;
    l = 0;
    p = '0;
    case (o)
      OP_MULT:  begin p = 64'(sa * sb); l = longint'(p); h = longint'(p >> w); end
      OP_MULTU: begin p = 64'(ua * ub); l = longint'(p); h = longint'(p >> w); end
      OP_DIV: begin
        if (ub == 0) begin l = mask; h = ua; rdz = 1'b1; end
        else begin l = sa / sb; h = sa % sb; end
      end
      OP_DIVU: begin
        if (ub == 0) begin l = mask; h = ua; rdz = 1'b1; end
        else begin l = ua / ub; h = ua % ub; end
      end
      default: ;
    endcase
    rhi = 32'(h & mask);
    rlo = 32'(l & mask);
  endfunction

  // Expected outputs of the 32-bit instance: an accepted mul/div completes WIDTH+1 edges later.
  int          m_cnt = 0;
  logic        m_done = 1'b0, m_dz = 1'b0, p_dz = 1'b0;
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  bit          chk_en = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_cnt = 0; m_hi = '0; m_lo = '0; m_done = 1'b0; m_dz = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_cnt > 0) begin
        if (abort) m_cnt = 0;
        else begin
          m_cnt--;
          if (m_cnt == 0) begin m_hi = p_hi; m_lo = p_lo; m_dz = p_dz; m_done = 1'b1; end
        end
      end else if (start && !abort) begin
        if (op == OP_MULT || op == OP_MULTU || op == OP_DIV || op == OP_DIVU) begin
          ref_op(32, op, in1, in2, p_hi, p_lo, p_dz);
          m_cnt = 33;
          m_dz  = 1'b0;
        end else if (op == OP_MTHI) begin
          m_hi = in1; m_done = 1'b1; m_dz = 1'b0;
        end else if (op == OP_MTLO) begin
          m_lo = in1; m_done = 1'b1; m_dz = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy",     32'(busy), 32'(m_cnt > 0));
      chk("done",     32'(done), 32'(m_done));
      chk("div_zero", 32'(dz),   32'(m_dz));
      chk("hi",       hi,        m_hi);
      chk("lo",       lo,        m_lo);
    end
  end

  task automatic issue(input logic [5:0] o, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    start = 1'b1; op = o; in1 = a; in2 = b;
    @(posedge clk); #1;
    start = 1'b0; op = 6'($urandom); in1 = $urandom; in2 = $urandom;
  endtask

  // Returns at the negedge where done is seen; edges = posedges after the accepting one.
  task automatic wait_done(input string name, output int edges, output int bcyc);
    int n = 0;
    bcyc = 0;
    while (n < 200) begin
      @(negedge clk);
      n++;
      if (busy) bcyc++;
      if (done) break;
    end
    edges = n - 1;
    if (!done) chk({name, "_timeout"}, 32'(done), 32'd1);
  endtask

  task automatic issue8(input logic [5:0] o, input logic [7:0] a, input logic [7:0] b);
    @(posedge clk); #1;
    start8 = 1'b1; op8 = o; a8 = a; b8 = b;
    @(posedge clk); #1;
    start8 = 1'b0; op8 = 6'($urandom); a8 = 8'($urandom); b8 = 8'($urandom);
  endtask

  task automatic wait_done8(input string name, output int edges, output int bcyc);
    int n = 0;
    bcyc = 0;
    while (n < 100) begin
      @(negedge clk);
      n++;
      if (busy8) bcyc++;
      if (done8) break;
    end
    edges = n - 1;
    if (!done8) chk({name, "_timeout"}, 32'(done8), 32'd1);
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom % 6)
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [5:0] pick_op();
    case ($urandom % 8)
      0: return OP_MULT;
      1: return OP_MULTU;
      2: return OP_DIV;
      3: return OP_DIVU;
      4: return OP_MTHI;
      5: return OP_MTLO;
      6: return 6'($urandom);
      default: return OP_DIV;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int e, bc, seen;
    logic [31:0] eh, el;
    logic        edz;
    logic [5:0]  ro;

    rst = 1'b1; start = 1'b0; abort = 1'b0; op = '0; in1 = '0; in2 = '0;
    start8 = 1'b0; abort8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_hi", hi, 32'h0);
    chk("reset_lo8", 32'(lo8), 32'h0);
    chk("reset_busy8", 32'(busy8), 32'h0);
    rst = 1'b0;

    issue(OP_MULT, 32'hFFFF_FFFD, 32'd5);
    wait_done("mult", e, bc);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFF1);
    chk("mult_done_edge", 32'(e), 32'd33);
    chk("mult_busy_cycles", 32'(bc), 32'd33);

    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("multu", e, bc);
    chk("multu_hi", hi, 32'hFFFF_FFFE);
    chk("multu_lo", lo, 32'h0000_0001);

    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_done("div", e, bc);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);

    issue(OP_DIVU, 32'd7, 32'd0);
    wait_done("divu0", e, bc);
    chk("divu0_lo", lo, 32'hFFFF_FFFF);
    chk("divu0_hi", hi, 32'h0000_0007);
    chk("divu0_flag", 32'(dz), 32'd1);
    issue(OP_MULT, 32'd2, 32'd3);
    chk("dz_cleared", 32'(dz), 32'd0);
    wait_done("mult2", e, bc);
    chk("mult2_lo", lo, 32'd6);

    issue(OP_MTHI, 32'hAAAA_AAAA, 32'd0);
    issue(OP_MTLO, 32'h5555_5555, 32'd0);
    issue(OP_DIV, 32'd100, 32'd7);
    repeat (8) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    seen = 0;
    repeat (40) begin @(negedge clk); if (done) seen++; end
    chk("abort_no_done", 32'(seen), 32'd0);
    chk("abort_hi", hi, 32'hAAAA_AAAA);
    chk("abort_lo", lo, 32'h5555_5555);

    issue(OP_MULTU, 32'd3, 32'd4);
    repeat (5) @(posedge clk);
    #1 start = 1'b1; op = OP_DIVU; in1 = 32'd9; in2 = 32'd3;
    repeat (2) @(posedge clk);
    #1 start = 1'b0;
    wait_done("busy_start", e, bc);
    chk("busy_start_lo", lo, 32'd12);
    chk("busy_start_hi", hi, 32'd0);

    issue(OP_MTHI, 32'h1234, 32'd0);
    issue(OP_MULT, 32'd5, 32'd6);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midreset_hi", hi, 32'h0);
    chk("midreset_lo", lo, 32'h0);
    chk("midreset_busy", 32'(busy), 32'd0);

    repeat (3000) begin
      @(posedge clk); #1;
      start = ($urandom % 4) == 0;
      op    = pick_op();
      in1   = pick_val();
      in2   = pick_val();
      abort = ($urandom % 40) == 0;
      rst   = ($urandom % 600) == 0;
    end
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0; rst = 1'b0;
    repeat (40) @(posedge clk);

    issue8(OP_DIV, 8'h80, 8'hFF);
    wait_done8("div8", e, bc);
    chk("div8_lo", 32'(lo8), 32'h80);
    chk("div8_hi", 32'(hi8), 32'h00);
    chk("div8_done_edge", 32'(e), 32'd9);
    chk("div8_busy_cycles", 32'(bc), 32'd9);

    issue8(OP_MULT, 8'h80, 8'h80);
    wait_done8("mult8", e, bc);
    chk("mult8_hi", 32'(hi8), 32'h40);
    chk("mult8_lo", 32'(lo8), 32'h00);

    repeat (80) begin
      ro = (($urandom % 4) == 0) ? OP_MULT : (($urandom % 3) == 0) ? OP_MULTU :
           (($urandom % 2) == 0) ? OP_DIV : OP_DIVU;
      a8 = 8'($urandom);
      b8 = (($urandom % 5) == 0) ? 8'h00 : 8'($urandom);
      ref_op(8, ro, 32'(a8), 32'(b8), eh, el, edz);
      issue8(ro, a8, b8);
      wait_done8("rand8", e, bc);
      chk("rand8_hi", 32'(hi8), eh);
      chk("rand8_lo", 32'(lo8), el);
      chk("rand8_dz", 32'(dz8), 32'(edz));
      chk("rand8_done_edge", 32'(e), 32'd9);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mdu_hilo.md
# mdu_hilo

Iterative multiply/divide unit that owns the architectural HI/LO register pair for WIDTH-bit operands. It executes MULT, MULTU, DIV, DIVU over multiple cycles with a start/busy/done handshake, and services MTHI/MTLO in a single cycle. It sits beside the combinational ALU in the execute stage. The pipeline stalls on `w_busy` and reads HI/LO directly for MFHI/MFLO.

## Interface
- `WIDTH`, default 32: operand, HI and LO width; must be ≥ 4 and even.
- `clock` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high.
- `w_start` in 1: request; sampled only when idle.
- `w_abort` in 1: pipeline flush; cancels the operation in flight.
- `w_op_code_6` in 6: `SPECIAL_MULT`, `SPECIAL_MULTU`, `SPECIAL_DIV`, `SPECIAL_DIVU`, `SPECIAL_MTHI`, `SPECIAL_MTLO` (codes from `isa_codes.v`).
- `w_input1_x` in WIDTH: rs (multiplicand/dividend; MTHI/MTLO source).
- `w_input2_x` in WIDTH: rt (multiplier/divisor).
- `w_busy` out 1: operation in flight.
- `w_done` out 1: one-cycle pulse when HI/LO are updated.
- `w_div_zero` out 1: last completed divide had a zero divisor.
- `w_hi_x` out WIDTH: HI register.
- `w_lo_x` out WIDTH: LO register.

## Operation
- **States:**
  - IDLE → CALC on an accepted mult/div start.
  - CALC → FIX after WIDTH iterations.
  - FIX → IDLE.
  - Any state → IDLE on `w_abort` or `reset`.
- **Acceptance:** a start is accepted when `w_start`=1, `w_abort`=0 and the state is IDLE. Operands and opcode are latched; later input changes have no effect.
- **Signed ops:** operands are converted to magnitudes at acceptance and the result signs are recorded.
  - Product sign = sign1 XOR sign2.
  - Quotient sign = sign1 XOR sign2.
  - Remainder sign = sign of the dividend.
- **Multiply:** radix-2 shift-add over a 2·WIDTH accumulator, one bit per CALC cycle. FIX negates the result if needed, then writes HI = upper WIDTH bits and LO = lower WIDTH bits.
- **Divide:** restoring division, one quotient bit per CALC cycle. FIX applies sign correction, then writes LO = quotient and HI = remainder.
  - Signed overflow (most-negative / −1): LO = most-negative, HI = 0.
- **Divide by zero** (divisor = 0 at acceptance): full latency still elapses. FIX writes LO = all-ones and HI = `w_input1_x` as latched, and sets `w_div_zero`=1.
- **`w_div_zero` lifetime:** cleared on every accepted start.
- **MTHI/MTLO:** when accepted in IDLE, the HI (or LO) register takes `w_input1_x` at that edge. The other register is unchanged. `w_done` pulses in the next cycle and `w_busy` stays 0.
- **Ignored requests:**
  - A start with any other opcode is ignored: no state change, no done.
  - A start while busy is ignored (the requester must hold it).
- **Abort:** `w_abort`=1 returns the block to IDLE at the next edge.
  - HI, LO and `w_div_zero` keep their pre-operation values.
  - No done pulse is produced.
  - Abort outranks start in every state.
- **Reset:** HI = 0, LO = 0, `w_busy` = 0, `w_done` = 0, `w_div_zero` = 0, state IDLE. Applies mid-operation as well; no done is produced.

## Timing
- **Start edge:** the edge sampling the accepted start is edge 0. `w_busy` goes to 1 after edge 0.
- **Iteration:** CALC iterates on edges 1..WIDTH. FIX is evaluated at edge WIDTH+1.
- **Completion:** after edge WIDTH+1, HI/LO hold the new value, `w_done`=1 for exactly one cycle and `w_busy`=0.
- **Busy window:** `w_busy` is high for WIDTH+1 cycles. Result latency is WIDTH+1 cycles (33 for WIDTH=32).
- **Back-to-back:** a new start is accepted in the cycle `w_done` is high, because the state is IDLE then.
- **MFHI/MFLO reads:** HI/LO outputs are registers. The values shown during busy are the old values. MFHI/MFLO forwarding is the pipeline's concern.
- **Simultaneous events:** the `w_done` cycle coinciding with an MTHI/MTLO start is legal; the MT write happens at that edge.

## Test plan
- **MULT, WIDTH=32:** MULT −3 × 5 → HI=FFFFFFFF, LO=FFFFFFF1. `w_done` after edge 33; `w_busy` high for 33 cycles.
- **MULTU:** FFFFFFFF × FFFFFFFF → HI=FFFFFFFE, LO=00000001.
- **DIV:** −7 / 2 → LO=FFFFFFFD, HI=FFFFFFFF.
- **DIVU by zero:** DIVU 7 / 0 → LO=FFFFFFFF, HI=00000007, `w_div_zero`=1. The next accepted MULT clears `w_div_zero`.
- **Abort:** preload HI=AAAAAAAA, LO=55555555 via MTHI/MTLO. Start DIV, then assert `w_abort` at cycle 10 → no done, HI/LO unchanged, `w_busy`=0 next cycle.
- **Start while busy:** a second start while busy is ignored.
- **Mid-operation reset:** reset at cycle 5 of a MULT → HI=LO=0.
- **WIDTH=8 build:**
  - DIV 0x80 / 0xFF → LO=0x80, HI=0x00; done after edge 9.
  - MULT 0x80 × 0x80 → HI=0x40, LO=0x00.
